bme280_i2c_slave: RTL

// - I2C responder (target) for the BME280 register map, at 7-bit address SLADDR. Inverse end of the
//   bme280_i2c_ctrl/i2c_master_top path; lets the meteo chain run on FPGA without a physical sensor.
// - Oversamples SCL/SDA on the system clock. Decodes START/STOP, address, register pointer and data.
// - Drives register read/write strobes to an external register model; open-drain SDA only, no clock stretching.

---
 rtl/bme280_i2c_slave.sv | 261 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/bme280_i2c_slave.sv
// ---------------------------------------------------------------------------
// bme280_i2c_slave
// I2C target that answers at 7-bit address SLADDR and exposes the BME280
// register map as strobes to an external register model. Lets the meteo
// chain talk to a simulated sensor on the FPGA instead of real hardware.
// SCL/SDA are oversampled on Clk; SDA is open-drain only and SCL is never
// stretched.
//
// Ports
//   Clk        system clock, at least 20x the SCL frequency
//   Rst        synchronous reset, active-high
//   SclPadIn   raw SCL pad level (asynchronous)
//   SdaPadIn   raw SDA pad level (asynchronous)
//   SdaPadOut  SDA drive value, always 0
//   SdaPadEn   1 = SDA released, 0 = drive SdaPadOut
//   Reg_addr   current register pointer
//   Reg_wdata  write data, valid with Reg_wr
//   Reg_wr     one-cycle write strobe
//   Reg_rd     one-cycle read request for the byte at Reg_addr
//   Reg_rdata  read data, sampled one Clk after Reg_rd
//   Busy       high while an addressed transaction is open
// ---------------------------------------------------------------------------
module bme280_i2c_slave #(
   parameter logic [6:0] SLADDR = 7'h76,
   parameter int         DWIDTH = 8
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              SclPadIn,
   input  logic              SdaPadIn,
   output logic              SdaPadOut,
   output logic              SdaPadEn,
   output logic [DWIDTH-1:0] Reg_addr,
   output logic [DWIDTH-1:0] Reg_wdata,
   output logic              Reg_wr,
   output logic              Reg_rd,
   input  logic [DWIDTH-1:0] Reg_rdata,
   output logic              Busy
);

   typedef enum logic [3:0] {
      IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
   } stateType;

   stateType          state, stateNext;
   logic              sclMeta, sclSync, sclPrev;
   logic              sdaMeta, sdaSync, sdaPrev;
   logic              sclRise, sclFall, startCond, stopCond;
   logic [3:0]        bitCnt, bitCntNext;
   logic [DWIDTH-1:0] rxReg, rxNext, rxShift;
   logic [DWIDTH-1:0] txReg, txNext;
   logic [DWIDTH-1:0] addrNext, wdataNext;
   logic              sdaEnNext, wrNext, rdNext, busyNext;
   logic              rdPending;

   assign SdaPadOut = 1'b0;

   // Two-flop synchronizer per pad plus one history flop so edges can be
   // seen. The reset value of 1 matches an idle bus and avoids a false
   // START or STOP right after reset.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         sclMeta <= 1'b1;
         sclSync <= 1'b1;
         sclPrev <= 1'b1;
         sdaMeta <= 1'b1;
         sdaSync <= 1'b1;
         sdaPrev <= 1'b1;
      end else begin
         sclMeta <= SclPadIn;
         sclSync <= sclMeta;
         sclPrev <= sclSync;
         sdaMeta <= SdaPadIn;
         sdaSync <= sdaMeta;
         sdaPrev <= sdaSync;
      end
   end

   // Bus events derived from the synchronized samples. START and STOP are
   // SDA edges while SCL is steady high.
   assign sclRise   = sclSync & ~sclPrev;
   assign sclFall   = ~sclSync & sclPrev;
   assign startCond = sclSync & sclPrev & sdaPrev & ~sdaSync;
   assign stopCond  = sclSync & sclPrev & ~sdaPrev & sdaSync;
   assign rxShift   = {rxReg[DWIDTH-2:0], sdaSync};

   // State register and every registered output. All next values come from
   // the combinational block below so the whole protocol lives in one place.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state     <= IDLE;
         bitCnt    <= 4'd0;
         rxReg     <= '0;
         txReg     <= '0;
         SdaPadEn  <= 1'b1;
         Reg_addr  <= '0;
         Reg_wdata <= '0;
         Reg_wr    <= 1'b0;
         Reg_rd    <= 1'b0;
         Busy      <= 1'b0;
         rdPending <= 1'b0;
      end else begin
         state     <= stateNext;
         bitCnt    <= bitCntNext;
         rxReg     <= rxNext;
         txReg     <= txNext;
         SdaPadEn  <= sdaEnNext;
         Reg_addr  <= addrNext;
         Reg_wdata <= wdataNext;
         Reg_wr    <= wrNext;
         Reg_rd    <= rdNext;
         Busy      <= busyNext;
         rdPending <= Reg_rd;
      end
   end

   // Protocol decoder. START and STOP override everything, so a byte cut
   // short by either never produces a strobe or a pointer change. SDA drive
   // only changes on a detected SCL fall; in the ACK states the first fall
   // starts driving the ACK and the second fall ends it. The pointer bumps
   // the cycle after Reg_wr so the strobe carries the address it wrote to,
   // and read data is captured one Clk after Reg_rd.
   always_comb begin
      stateNext  = state;
      bitCntNext = bitCnt;
      rxNext     = rxReg;
      txNext     = txReg;
      sdaEnNext  = SdaPadEn;
      addrNext   = Reg_addr;
      wdataNext  = Reg_wdata;
      wrNext     = 1'b0;
      rdNext     = 1'b0;
      busyNext   = Busy;

      if (Reg_wr) begin
         addrNext = Reg_addr + 8'd1;
      end
      if (rdPending) begin
         txNext = Reg_rdata;
      end

      if (startCond) begin
         stateNext  = ADDR;
         bitCntNext = 4'd0;
         sdaEnNext  = 1'b1;
      end else if (stopCond) begin
         stateNext  = IDLE;
         bitCntNext = 4'd0;
         sdaEnNext  = 1'b1;
         busyNext   = 1'b0;
      end else begin
         case (state)
            ADDR: begin
               if (sclRise) begin
                  rxNext     = rxShift;
                  bitCntNext = bitCnt + 4'd1;
                  if (bitCnt == 4'd7) begin
                     bitCntNext = 4'd0;
                     if (rxShift[7:1] == SLADDR) begin
                        stateNext = ADDR_ACK;
                        busyNext  = 1'b1;
                        rdNext    = rxShift[0];
                     end else begin
                        stateNext = IGNORE;
                        busyNext  = 1'b0;
                     end
                  end
               end
            end
            ADDR_ACK: begin
               if (sclFall) begin
                  if (SdaPadEn) begin
                     sdaEnNext = 1'b0;
                  end else if (rxReg[0]) begin
                     sdaEnNext  = txReg[7];
                     txNext     = {txReg[DWIDTH-2:0], 1'b0};
                     bitCntNext = 4'd1;
                     stateNext  = RDATA;
                  end else begin
                     sdaEnNext = 1'b1;
                     stateNext = PTR;
                  end
               end
            end
            PTR: begin
               if (sclRise) begin
                  rxNext     = rxShift;
                  bitCntNext = bitCnt + 4'd1;
                  if (bitCnt == 4'd7) begin
                     bitCntNext = 4'd0;
                     addrNext   = rxShift;
                     stateNext  = PTR_ACK;
                  end
               end
            end
            PTR_ACK: begin
               if (sclFall) begin
                  sdaEnNext = ~SdaPadEn;
                  if (!SdaPadEn) begin
                     stateNext = WDATA;
                  end
               end
            end
            WDATA: begin
               if (sclRise) begin
                  rxNext     = rxShift;
                  bitCntNext = bitCnt + 4'd1;
                  if (bitCnt == 4'd7) begin
                     bitCntNext = 4'd0;
                     stateNext  = WDATA_ACK;
                  end
               end
            end
            WDATA_ACK: begin
               if (sclRise) begin
                  wrNext    = 1'b1;
                  wdataNext = rxReg;
               end
               if (sclFall) begin
                  sdaEnNext = ~SdaPadEn;
                  if (!SdaPadEn) begin
                     stateNext = WDATA;
                  end
               end
            end
            RDATA: begin
               if (sclFall) begin
                  if (bitCnt == 4'd8) begin
                     sdaEnNext  = 1'b1;
                     bitCntNext = 4'd0;
                     stateNext  = RDATA_ACK;
                  end else begin
                     sdaEnNext  = txReg[7];
                     txNext     = {txReg[DWIDTH-2:0], 1'b0};
                     bitCntNext = bitCnt + 4'd1;
                  end
               end
            end
            RDATA_ACK: begin
               if (sclRise) begin
                  addrNext = Reg_addr + 8'd1;
                  if (!sdaSync) begin
                     rdNext    = 1'b1;
                     stateNext = RDATA;
                  end else begin
                     busyNext  = 1'b0;
                     stateNext = IGNORE;
                  end
               end
            end
            IDLE, IGNORE: begin
               stateNext = state;
            end
            default: begin
               stateNext = IDLE;
            end
         endcase
      end
   end

endmodule
